data_path: RTL and testbench

- Single-cycle register-file datapath: 4 x 32-bit general registers, two combinational read ports feeding a 2-bit-opcode ALU, and one synchronous write port.
- Write-back data is selected from the ALU result or one of two immediates.
- Sits under the control unit, which drives register selectors, source select, write enable and ALU opcode every cycle.

---
 rtl/data_path_pkg.sv | 22 ++
 rtl/data_path_if.sv | 33 +++
 rtl/data_path_alu.sv | 37 +++
 rtl/data_path_register_file.sv | 44 ++++
 rtl/data_path.sv | 56 +++++
 tb/tb_data_path.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/data_path_pkg.sv
// Shared constants and enums for the register-file datapath.
package data_path_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned REG_COUNT     = 4;
  localparam int unsigned REG_SEL_WIDTH = $clog2(REG_COUNT);

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_IMM1 = 2'd1,
    SRC_IMM2 = 2'd2,
    SRC_ZERO = 2'd3
  } wr_src_e;

endpackage

// File: rtl/data_path_if.sv
// Control-unit <-> datapath bus: selectors, opcode and immediates in, read data and flags out.
interface data_path_if;
  import data_path_pkg::*;

  logic [REG_SEL_WIDTH-1:0] input_register_selector_1;
  logic [REG_SEL_WIDTH-1:0] input_register_selector_2;
  logic [REG_SEL_WIDTH-1:0] output_register_selector;
  wr_src_e                  output_source_selector;
  logic                     output_enable;
  alu_op_e                  alu_opcode;
  logic [DATA_WIDTH-1:0]    immediate_1;
  logic [DATA_WIDTH-1:0]    immediate_2;
  logic [DATA_WIDTH-1:0]    input_data_1;
  logic [DATA_WIDTH-1:0]    input_data_2;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_carry;
  logic                     alu_zero;

  // Control unit side.
  modport master (
    output input_register_selector_1, input_register_selector_2, output_register_selector,
    output output_source_selector, output_enable, alu_opcode, immediate_1, immediate_2,
    input  input_data_1, input_data_2, alu_result, alu_carry, alu_zero
  );

  // Datapath side.
  modport slave (
    input  input_register_selector_1, input_register_selector_2, output_register_selector,
    input  output_source_selector, output_enable, alu_opcode, immediate_1, immediate_2,
    output input_data_1, input_data_2, alu_result, alu_carry, alu_zero
  );

endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: AND/OR/ADD/SUB with carry (NOT borrow for SUB) and zero flag.
module data_path_alu
  import data_path_pkg::*;
(
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] b_op;
  logic                  sub;

  // SUB is A + ~B + 1 so the adder carry-out doubles as NOT borrow.
  always_comb begin
    sub    = (op == ALU_SUB);
    b_op   = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, sub};
    result = '0;
    carry  = 1'b0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD, ALU_SUB: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/data_path_register_file.sv
// Register file: two combinational read ports, one synchronous write port, async clear.
module data_path_register_file
  import data_path_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_SEL_WIDTH-1:0] raddr_1,
  input  logic [REG_SEL_WIDTH-1:0] raddr_2,
  input  logic [REG_SEL_WIDTH-1:0] waddr,
  input  logic                     wen,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata_1,
  output logic [DATA_WIDTH-1:0]    rdata_2
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q;
  logic [REG_COUNT-1:0]                 reg_we;

  // Per-register write strobes; gated by wen first so an unknown waddr cannot leak through.
  always_comb begin
    reg_we = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      reg_we[i] = wen && (waddr == REG_SEL_WIDTH'(i));
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (reg_we[i]) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  // No write-through: reads always see the pre-edge contents.
  assign rdata_1 = regs_q[raddr_1];
  assign rdata_2 = regs_q[raddr_2];

endmodule

// File: rtl/data_path.sv
// Single-cycle datapath: register file, ALU and write-back source mux.
module data_path
  import data_path_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  data_path_if.slave bus
);

  logic [DATA_WIDTH-1:0] rdata_1;
  logic [DATA_WIDTH-1:0] rdata_2;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_z;
  logic [DATA_WIDTH-1:0] wdata;

  data_path_register_file u_register_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_1 (bus.input_register_selector_1),
    .raddr_2 (bus.input_register_selector_2),
    .waddr   (bus.output_register_selector),
    .wen     (bus.output_enable),
    .wdata   (wdata),
    .rdata_1 (rdata_1),
    .rdata_2 (rdata_2)
  );

  data_path_alu u_alu (
    .op     (bus.alu_opcode),
    .a      (rdata_1),
    .b      (rdata_2),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Write-back source select.
  always_comb begin
    wdata = '0;
    unique case (bus.output_source_selector)
      SRC_ALU:  wdata = alu_res;
      SRC_IMM1: wdata = bus.immediate_1;
      SRC_IMM2: wdata = bus.immediate_2;
      SRC_ZERO: wdata = '0;
      default:  wdata = '0;
    endcase
  end

  assign bus.input_data_1 = rdata_1;
  assign bus.input_data_2 = rdata_2;
  assign bus.alu_result   = alu_res;
  assign bus.alu_carry    = alu_c;
  assign bus.alu_zero     = alu_z;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path.
module tb_data_path;
  import data_path_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_path_if bus ();

  data_path u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input logic [1:0] a, input logic [1:0] b);
    bus.input_register_selector_1 = a;
    bus.input_register_selector_2 = b;
    #1;
  endtask

  task automatic write_reg(input logic [1:0] dst, input wr_src_e src,
                           input logic [31:0] imm1, input logic [31:0] imm2);
    bus.output_register_selector = dst;
    bus.output_source_selector   = src;
    bus.immediate_1              = imm1;
    bus.immediate_2              = imm2;
    bus.output_enable            = 1'b1;
    tick();
    bus.output_enable            = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.input_register_selector_1 = 2'd0;
    bus.input_register_selector_2 = 2'd0;
    bus.output_register_selector  = 2'd0;
    bus.output_source_selector    = SRC_IMM1;
    bus.output_enable             = 1'b0;
    bus.alu_opcode                = ALU_AND;
    bus.immediate_1               = 32'd0;
    bus.immediate_2               = 32'd0;

    // Reset state.
    #2;
    check_eq("rst_rd1", bus.input_data_1, 32'd0);
    check_eq("rst_rd2", bus.input_data_2, 32'd0);
    check_eq("rst_alu", bus.alu_result, 32'd0);
    check_eq("rst_zero", {31'd0, bus.alu_zero}, 32'd1);
    tick();
    tick();
    #3;
    rst_n = 1'b1;

    // Load r0..r3 from immediate_1.
    for (int i = 0; i < 4; i++) begin
      write_reg(2'(i), SRC_IMM1, 32'd21 << i, 32'd0);
    end
    set_read(2'd0, 2'd1);
    check_eq("r0", bus.input_data_1, 32'd21);
    check_eq("r1", bus.input_data_2, 32'd42);
    set_read(2'd2, 2'd3);
    check_eq("r2", bus.input_data_1, 32'd84);
    check_eq("r3", bus.input_data_2, 32'd168);

    // ADD r2+r3 into r0.
    bus.alu_opcode = ALU_ADD;
    bus.output_register_selector = 2'd0;
    bus.output_source_selector   = SRC_ALU;
    bus.output_enable            = 1'b1;
    #1;
    check_eq("add_res", bus.alu_result, 32'd252);
    check_eq("add_zero", {31'd0, bus.alu_zero}, 32'd0);
    check_eq("add_carry", {31'd0, bus.alu_carry}, 32'd0);
    tick();
    bus.output_enable = 1'b0;
    set_read(2'd0, 2'd0);
    check_eq("wb_rd1", bus.input_data_1, 32'd252);
    check_eq("wb_rd2", bus.input_data_2, 32'd252);

    // Disabled write leaves r1 alone.
    bus.output_register_selector = 2'd1;
    bus.output_source_selector   = SRC_IMM1;
    bus.immediate_1              = 32'd999;
    bus.output_enable            = 1'b0;
    tick();
    set_read(2'd1, 2'd1);
    check_eq("noen_r1", bus.input_data_1, 32'd42);

    // Unknown write selector with enable low.
    bus.output_register_selector = 2'bxx;
    tick();
    set_read(2'd0, 2'd1);
    check_eq("xsel_r0", bus.input_data_1, 32'd252);
    check_eq("xsel_r1", bus.input_data_2, 32'd42);

    // Carry/zero edge cases; r1 loaded through immediate_2.
    write_reg(2'd0, SRC_IMM1, 32'hFFFF_FFFF, 32'd0);
    write_reg(2'd1, SRC_IMM2, 32'd0, 32'd1);
    bus.alu_opcode = ALU_ADD;
    set_read(2'd0, 2'd1);
    check_eq("imm2_r1", bus.input_data_2, 32'd1);
    check_eq("ovf_res", bus.alu_result, 32'd0);
    check_eq("ovf_carry", {31'd0, bus.alu_carry}, 32'd1);
    check_eq("ovf_zero", {31'd0, bus.alu_zero}, 32'd1);
    bus.alu_opcode = ALU_SUB;
    set_read(2'd1, 2'd0);
    check_eq("sub_res", bus.alu_result, 32'd2);
    check_eq("sub_carry", {31'd0, bus.alu_carry}, 32'd0);
    set_read(2'd0, 2'd1);
    check_eq("sub2_res", bus.alu_result, 32'hFFFF_FFFE);
    check_eq("sub2_carry", {31'd0, bus.alu_carry}, 32'd1);

    // Logic ops.
    write_reg(2'd2, SRC_IMM1, 32'hF0F0_F0F0, 32'd0);
    write_reg(2'd3, SRC_IMM2, 32'd0, 32'h0FF0_0FF0);
    set_read(2'd2, 2'd3);
    bus.alu_opcode = ALU_AND;
    #1;
    check_eq("and_res", bus.alu_result, 32'h00F0_00F0);
    check_eq("and_carry", {31'd0, bus.alu_carry}, 32'd0);
    bus.alu_opcode = ALU_OR;
    #1;
    check_eq("or_res", bus.alu_result, 32'hFFF0_FFF0);

    // Read-modify-write r2 <= r2 & r3; old value visible until the edge.
    bus.alu_opcode               = ALU_AND;
    bus.output_register_selector = 2'd2;
    bus.output_source_selector   = SRC_ALU;
    bus.output_enable            = 1'b1;
    #1;
    check_eq("rmw_pre", bus.input_data_1, 32'hF0F0_F0F0);
    tick();
    bus.output_enable = 1'b0;
    check_eq("rmw_post", bus.input_data_1, 32'h00F0_00F0);

    // Zero source clears r3.
    write_reg(2'd3, SRC_ZERO, 32'h5555_5555, 32'hAAAA_AAAA);
    set_read(2'd2, 2'd3);
    check_eq("zero_src", bus.input_data_2, 32'd0);

    // Asynchronous reset mid-cycle, and an enabled write blocked while held.
    tick();
    #3;
    set_read(2'd0, 2'd1);
    bus.output_register_selector = 2'd0;
    bus.output_source_selector   = SRC_IMM1;
    bus.immediate_1              = 32'h0000_1234;
    bus.output_enable            = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_r0", bus.input_data_1, 32'd0);
    check_eq("arst_r1", bus.input_data_2, 32'd0);
    tick();
    check_eq("arst_wr", bus.input_data_1, 32'd0);
    #3;
    bus.output_enable = 1'b0;
    rst_n = 1'b1;
    set_read(2'd2, 2'd0);
    check_eq("arst_r2", bus.input_data_1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
